// File: rtl/assoc_cache_2way.sv
// Two-way set-associative tag store with LRU replacement, answering the state/addr_in/hit lookup protocol.
// Optional saturating hit/miss statistics are built only when CACHE_STATS_EN is defined.
module assoc_cache_2way #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned INDEX_W  = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              state,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  localparam int unsigned SETS  = 1 << INDEX_W;

  logic [SETS-1:0]    valid0;
  logic [SETS-1:0]    valid1;
  logic [SETS-1:0]    lru;
  logic [TAG_W-1:0]   tag0 [SETS];
  logic [TAG_W-1:0]   tag1 [SETS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit0;
  logic               hit1;
  logic               lookup_hit;
  logic               victim;
  logic               lookup;
  logic               unused_offset;

  assign idx           = addr_in[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag           = addr_in[ADDR_W-1:OFFSET_W+INDEX_W];
  assign lookup        = ~state;
  assign unused_offset = ^addr_in[OFFSET_W-1:0];

  always_comb begin
    hit0       = 1'b0;
    hit1       = 1'b0;
    lookup_hit = 1'b0;
    victim     = 1'b0;
    hit0       = valid0[idx] && (tag0[idx] == tag);
    hit1       = valid1[idx] && (tag1[idx] == tag);
    lookup_hit = hit0 | hit1;
    // Fill an empty way first (way0 preferred), else evict the LRU way.
    if (!valid0[idx])      victim = 1'b0;
    else if (!valid1[idx]) victim = 1'b1;
    else                   victim = lru[idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
      hit    <= 1'b0;
    end else if (lookup) begin
      hit <= lookup_hit;
      if (hit0) begin
        lru[idx] <= 1'b1;
      end else if (hit1) begin
        lru[idx] <= 1'b0;
      end else begin
        lru[idx] <= ~victim;
        if (victim) valid1[idx] <= 1'b1;
        else        valid0[idx] <= 1'b1;
      end
    end
  end

  // Tags need no reset: a way is only trusted while its valid bit is set.
  always_ff @(posedge clk) begin
    if (lookup && !lookup_hit) begin
      if (victim) tag1[idx] <= tag;
      else        tag0[idx] <= tag;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (lookup) begin
      if (lookup_hit) begin
        if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
